// File: rtl/sm4_uart_tx_if.sv
// rtl/sm4_uart_tx_if.sv - byte FIFO read port between the SM4 splitter FIFO and the UART egress
interface sm4_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/sm4_uart_tx.sv
// rtl/sm4_uart_tx.sv - 8N1 UART transmitter draining the SM4 ciphertext byte FIFO
// Pulses byte_done per frame and blk_done on every 16th byte (one 128-bit block).
module sm4_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic           clk,
  input  logic           rst,
  sm4_uart_tx_if.master  fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done,
  output logic           blk_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, RD, WAIT, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            rd_en_q, rd_en_d;
  logic            busy_q, busy_d;
  logic            byte_done_q, byte_done_d;
  logic            blk_done_q, blk_done_d;
  logic            bit_end;

  assign bit_end = (baud_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      blk_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      blk_done_q  <= blk_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo.fifo_empty) state_d = RD;
      RD:      state_d = WAIT;
      WAIT:    state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rd_en_d     = 1'b0;
    busy_d      = busy_q;
    byte_done_d = 1'b0;
    blk_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo.fifo_empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        // FIFO data is valid now, one cycle after it saw the strike
        shift_d    = fifo.fifo_dout;
        tx_d       = 1'b0;
        baud_cnt_d = '0;
      end
      START: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
        end
      end
      DATA: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        if (bit_end) begin
          byte_done_d = 1'b1;
          busy_d      = 1'b0;
          byte_cnt_d  = byte_cnt_q + 4'd1;
          blk_done_d  = (byte_cnt_q == 4'd15);
        end
      end
      default: ;
    endcase
  end

  assign tx              = tx_q;
  assign busy            = busy_q;
  assign byte_done       = byte_done_q;
  assign blk_done        = blk_done_q;
  assign fifo.fifo_rd_en = rd_en_q;
endmodule

// File: tb/tb_sm4_uart_tx.sv
// tb/tb_sm4_uart_tx.sv - scoreboard bench for sm4_uart_tx with CLKS_PER_BIT=8
module tb_sm4_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy, byte_done, blk_done;
  logic glitch = 1'b0;

  sm4_uart_tx_if fif();

  sm4_uart_tx #(.CLK_FREQ(8), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .fifo(fif.master),
    .tx(tx), .busy(busy), .byte_done(byte_done), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered read data, empty from write/read pointers
  logic [7:0] mem [0:127];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fif.fifo_empty = (wr_cnt == rd_cnt) && !glitch;
  always @(posedge clk) begin
    if (fif.fifo_rd_en) begin
      fif.fifo_dout <= mem[rd_cnt % 128];
      rd_cnt <= rd_cnt + 1;
    end
  end

  logic [7:0] exp_q [$];
  task automatic push_byte(input logic [7:0] b);
    mem[wr_cnt % 128] = b;
    wr_cnt++;
    exp_q.push_back(b);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // line monitor: samples each cycle, decodes frames and checks bit timing
  int strikes = 0, bd_count = 0, last_strike = 0, last_start = 0, last_gap = 0;
  int blk_q [$];
  logic prev_tx = 1'b1, prev_rd = 1'b0, prev_bd = 1'b0;
  logic mon_active = 1'b0, mon_level = 1'b0, mon_steady = 1'b0;
  int mon_bit = 0, mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (fif.fifo_rd_en) begin
        strikes++;
        last_strike = cyc;
        chk("strike_width", prev_rd, 1'b0);
      end
      if (byte_done) begin
        bd_count++;
        chk("done_pulse", prev_bd, 1'b0);
        chk("busy_at_done", busy, 1'b0);
      end
      if (blk_done) begin
        chk("blk_with_byte", byte_done, 1'b1);
        blk_q.push_back(bd_count);
      end
      if (!mon_active) begin
        if (prev_tx && !tx) begin
          mon_active = 1'b1; mon_bit = 0; mon_cnt = 1; mon_level = 1'b0; mon_steady = 1'b1;
          chk("start_latency", cyc - last_strike, 2);
          last_gap = cyc - last_start;
          last_start = cyc;
        end
      end else begin
        if (mon_cnt == 8) begin
          if (mon_bit >= 1 && mon_bit <= 8) mon_byte[mon_bit-1] = mon_level;
          if (mon_bit == 9) begin
            mon_active = 1'b0;
            chk("frame_steady", mon_steady, 1'b1);
            chk("stop_bit", mon_level, 1'b1);
            if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
            else chk("frame_data", mon_byte, exp_q.pop_front());
          end else begin
            mon_bit++; mon_cnt = 0; mon_level = tx;
          end
        end
        if (mon_active) begin
          if (tx !== mon_level) mon_steady = 1'b0;
          mon_cnt++;
        end
      end
    end
    prev_tx = tx;
    prev_rd = fif.fifo_rd_en;
    prev_bd = byte_done;
  end

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (bd_count < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, bd_count, n);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int base, s0;

  initial begin
    // (1) reset with a byte waiting
    push_byte(8'hA5);
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_rd_en", fif.fifo_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_strike", fif.fifo_rd_en, 1'b1);
    @(posedge clk); #1;
    chk("strike_drop", fif.fifo_rd_en, 1'b0);
    chk("busy_after_strike", busy, 1'b1);
    // (2) single byte 0xA5
    wait_done(1, 200, "single_done");
    chk("single_strikes", strikes, 1);

    // (3) back-to-back 0x00, 0xFF
    @(negedge clk);
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_done(3, 400, "b2b_done");
    chk("b2b_gap", last_gap, 83);
    repeat (30) @(negedge clk);
    chk("b2b_strikes", strikes, 3);
    chk("b2b_idle_tx", tx, 1'b1);

    // (4) 32-byte stream after a fresh reset
    reset_pulse();
    blk_q.delete();
    base = bd_count;
    for (int i = 0; i < 32; i++) push_byte(8'($urandom_range(0, 255)));
    wait_done(base + 32, 32 * 83 + 200, "stream_done");
    chk("blk_count", blk_q.size(), 2);
    if (blk_q.size() == 2) begin
      chk("blk_first", blk_q[0], base + 16);
      chk("blk_second", blk_q[1], base + 32);
    end

    // (5) reset during data bit 3 of 0x3C, then 16 bytes from 0x81
    push_byte(8'h11);
    wait_done(base + 33, 200, "pre_abort_done");
    push_byte(8'h3C);
    s0 = 0;
    while (!(mon_active && mon_bit == 4 && mon_cnt >= 3) && s0 < 300) begin
      @(negedge clk);
      s0++;
    end
    chk("reach_bit3", mon_bit, 4);
    chk("bit3_level", tx, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    blk_q.delete();
    base = bd_count;
    push_byte(8'h81);
    for (int i = 1; i < 16; i++) push_byte(8'(i * 17 + 3));
    wait_done(base + 16, 16 * 83 + 200, "post_rst_done");
    chk("post_rst_blk_count", blk_q.size(), 1);
    if (blk_q.size() == 1) chk("post_rst_blk_idx", blk_q[0], base + 16);

    // (6) empty glitch while busy, then a byte arriving mid-frame
    base = strikes;
    push_byte(8'h5A);
    s0 = 0;
    while (!(mon_active && mon_bit == 2) && s0 < 300) begin
      @(negedge clk);
      s0++;
    end
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    chk("glitch_no_strike", strikes, base + 1);
    while (!(mon_active && mon_bit == 5) && s0 < 600) begin
      @(negedge clk);
      s0++;
    end
    push_byte(8'hC3);
    wait_done(bd_count + 2, 400, "glitch_done");
    chk("glitch_strikes", strikes, base + 2);
    chk("glitch_gap", last_gap, 83);
    repeat (20) @(negedge clk);
    chk("final_idle_tx", tx, 1'b1);
    chk("final_strikes", strikes, base + 2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
